// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 core: FSM encoding, opcode class nibbles,
// font layout and the RND LFSR step.
package chip8_pkg;

  typedef enum logic [2:0] {
    S_FETCH_H = 3'd0,
    S_FETCH_L = 3'd1,
    S_EXEC    = 3'd2,
    S_DRAW    = 3'd3,
    S_HALT    = 3'd4
  } state_e;

  localparam logic [3:0] OP_SYS   = 4'h0;
  localparam logic [3:0] OP_JP    = 4'h1;
  localparam logic [3:0] OP_CALL  = 4'h2;
  localparam logic [3:0] OP_SE_I  = 4'h3;
  localparam logic [3:0] OP_SNE_I = 4'h4;
  localparam logic [3:0] OP_SE_R  = 4'h5;
  localparam logic [3:0] OP_LD_I  = 4'h6;
  localparam logic [3:0] OP_ADD_I = 4'h7;
  localparam logic [3:0] OP_ALU   = 4'h8;
  localparam logic [3:0] OP_SNE_R = 4'h9;
  localparam logic [3:0] OP_LDI   = 4'hA;
  localparam logic [3:0] OP_JPV   = 4'hB;
  localparam logic [3:0] OP_RND   = 4'hC;
  localparam logic [3:0] OP_DRW   = 4'hD;
  localparam logic [3:0] OP_KEY   = 4'hE;
  localparam logic [3:0] OP_MISC  = 4'hF;

  localparam int FONT_BASE   = 0;
  localparam int FONT_STRIDE = 5;

  // Fibonacci form of x^16+x^14+x^13+x^11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/chip8_if.sv
// Program-memory read port and draw-unit handshake between the core (master)
// and the surrounding system (slave).
interface chip8_if #(parameter int ADDR_WIDTH = 12);
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [7:0]            mem_q;
  logic                  draw_req;
  logic                  draw_busy;
  logic                  draw_col;
  logic [10:0]           draw_start_pix;
  logic [3:0]            draw_nibbles;
  logic [ADDR_WIDTH-1:0] draw_I;

  modport master (
    output mem_re, mem_raddr, draw_req, draw_start_pix, draw_nibbles, draw_I,
    input  mem_q, draw_busy, draw_col
  );

  modport slave (
    input  mem_re, mem_raddr, draw_req, draw_start_pix, draw_nibbles, draw_I,
    output mem_q, draw_busy, draw_col
  );
endinterface

// File: rtl/chip8_timer.sv
// 8-bit CHIP-8 delay/sound timer: loadable, decrements on the shared tick and
// saturates at zero. A load coincident with a tick takes precedence.
module chip8_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] cnt_o
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (tick_i && cnt_q != '0) cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/chip8_core.sv
// CHIP-8 fetch/decode/execute engine with call stack, timers, keypad skips,
// LFSR RND and a DXYN handoff to an external draw unit.
//  state     | meaning
//  S_FETCH_H | read opcode high byte at PC
//  S_FETCH_L | latch high byte, read low byte at PC+1
//  S_EXEC    | decode/execute, update PC
//  S_DRAW    | draw unit owns memory; wait busy high then low
//  S_HALT    | sticky fault, only reset leaves
module chip8_core
  import chip8_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          PC_RESET    = 512,
  parameter int          STACK_DEPTH = 16,
  parameter int          CLK_HZ      = 12000000,
  parameter int          TIMER_HZ    = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  chip8_if.master     bus,
  input  logic [15:0] keys,
  output logic        sound,
  output logic        halted
);
  localparam int AW       = ADDR_WIDTH;
  localparam int SPW      = $clog2(STACK_DEPTH + 1);
  localparam int SIW      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int PRESCALE = CLK_HZ / TIMER_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [AW-1:0]  PC_RST = AW'(PC_RESET);
  localparam logic [AW-1:0]  ONE    = AW'(1);
  localparam logic [AW-1:0]  TWO    = AW'(2);
  localparam logic [AW-1:0]  FOUR   = AW'(4);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d, i_q, i_d, raddr;
  logic [7:0]      v_q [16];
  logic [AW-1:0]   stack_q [STACK_DEPTH];
  logic [SPW-1:0]  sp_q, sp_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     lfsr_q;
  logic [PW-1:0]   presc_q;
  logic            busy_seen_q, busy_seen_d, req_q, req_d;
  logic [10:0]     pix_q, pix_d;
  logic [3:0]      nib_q, nib_d;
  logic            v_wr, vf_wr, vf_wd, push, dt_ld, st_ld, fault, tick, mem_re;
  logic [3:0]      v_wa;
  logic [7:0]      v_wd, dt_cnt, st_cnt;
  logic [3:0]      x, y, n;
  logic [7:0]      nn, vx, vy;
  logic [AW-1:0]   nnn;
  logic [8:0]      sum9;
  logic [SIW-1:0]  push_idx, pop_idx;

  assign x        = hi_q[3:0];
  assign y        = bus.mem_q[7:4];
  assign n        = bus.mem_q[3:0];
  assign nn       = bus.mem_q;
  assign nnn      = AW'({hi_q[3:0], bus.mem_q});
  assign vx       = v_q[x];
  assign vy       = v_q[y];
  assign sum9     = {1'b0, vx} + {1'b0, vy};
  assign push_idx = SIW'(sp_q);
  assign pop_idx  = SIW'(sp_q - SP_ONE);
  assign tick     = (presc_q == '0);

  always_comb begin
    state_d = state_q;  pc_d = pc_q;  i_d = i_q;  sp_d = sp_q;  hi_d = hi_q;
    busy_seen_d = busy_seen_q;  req_d = 1'b0;  pix_d = pix_q;  nib_d = nib_q;
    v_wr = 1'b0;  v_wa = x;  v_wd = 8'h00;  vf_wr = 1'b0;  vf_wd = 1'b0;
    push = 1'b0;  dt_ld = 1'b0;  st_ld = 1'b0;  fault = 1'b0;
    mem_re = 1'b0;  raddr = pc_q;
    case (state_q)
      S_FETCH_H: begin
        mem_re  = 1'b1;
        state_d = S_FETCH_L;
      end
      S_FETCH_L: begin
        mem_re  = 1'b1;
        raddr   = pc_q + ONE;
        hi_d    = bus.mem_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH_H;
        pc_d    = pc_q + TWO;
        case (hi_q[7:4])
          OP_SYS: begin
            if (hi_q == 8'h00 && nn == 8'hEE && sp_q != '0) begin
              sp_d = sp_q - SP_ONE;
              pc_d = stack_q[pop_idx];
            end else fault = 1'b1;
          end
          OP_JP:    pc_d = nnn;
          OP_CALL: begin
            if (sp_q == SP_MAX) fault = 1'b1;
            else begin
              push = 1'b1;
              sp_d = sp_q + SP_ONE;
              pc_d = nnn;
            end
          end
          OP_SE_I:  if (vx == nn) pc_d = pc_q + FOUR;
          OP_SNE_I: if (vx != nn) pc_d = pc_q + FOUR;
          OP_SE_R: begin
            if (n != 4'h0)    fault = 1'b1;
            else if (vx == vy) pc_d = pc_q + FOUR;
          end
          OP_LD_I:  begin v_wr = 1'b1; v_wd = nn; end
          OP_ADD_I: begin v_wr = 1'b1; v_wd = vx + nn; end
          OP_ALU: begin
            v_wr = 1'b1;
            case (n)
              4'h0: v_wd = vy;
              4'h1: v_wd = vx | vy;
              4'h2: v_wd = vx & vy;
              4'h3: v_wd = vx ^ vy;
              4'h4: begin v_wd = sum9[7:0];       vf_wr = 1'b1; vf_wd = sum9[8];  end
              4'h5: begin v_wd = vx - vy;         vf_wr = 1'b1; vf_wd = (vx >= vy); end
              4'h6: begin v_wd = {1'b0, vx[7:1]}; vf_wr = 1'b1; vf_wd = vx[0];    end
              4'h7: begin v_wd = vy - vx;         vf_wr = 1'b1; vf_wd = (vy >= vx); end
              4'hE: begin v_wd = {vx[6:0], 1'b0}; vf_wr = 1'b1; vf_wd = vx[7];    end
              default: begin v_wr = 1'b0; fault = 1'b1; end
            endcase
          end
          OP_SNE_R: begin
            if (n != 4'h0)    fault = 1'b1;
            else if (vx != vy) pc_d = pc_q + FOUR;
          end
          OP_LDI:   i_d  = nnn;
          OP_JPV:   pc_d = nnn + AW'(v_q[0]);
          OP_RND:   begin v_wr = 1'b1; v_wd = lfsr_q[7:0] & nn; end
          OP_DRW: begin
            state_d     = S_DRAW;
            pc_d        = pc_q;
            req_d       = 1'b1;
            busy_seen_d = 1'b0;
            pix_d       = {vy[4:0], vx[5:0]};
            nib_d       = n;
          end
          OP_KEY: begin
            if (nn == 8'h9E)      begin if (keys[vx[3:0]])  pc_d = pc_q + FOUR; end
            else if (nn == 8'hA1) begin if (!keys[vx[3:0]]) pc_d = pc_q + FOUR; end
            else fault = 1'b1;
          end
          OP_MISC: begin
            case (nn)
              8'h07:   begin v_wr = 1'b1; v_wd = dt_cnt; end
              8'h15:   dt_ld = 1'b1;
              8'h18:   st_ld = 1'b1;
              8'h1E:   i_d = i_q + AW'(vx);
              8'h29:   i_d = AW'(FONT_BASE + FONT_STRIDE * int'(vx[3:0]));
              default: fault = 1'b1;
            endcase
          end
          default: fault = 1'b1;
        endcase
        if (fault) begin
          state_d = S_HALT;
          pc_d    = pc_q;
        end
      end
      S_DRAW: begin
        if (bus.draw_busy) busy_seen_d = 1'b1;
        else if (busy_seen_q) begin
          busy_seen_d = 1'b0;
          vf_wr       = 1'b1;
          vf_wd       = bus.draw_col;
          pc_d        = pc_q + TWO;
          state_d     = S_FETCH_H;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH_H;
      pc_q        <= PC_RST;
      i_q         <= '0;
      sp_q        <= '0;
      hi_q        <= '0;
      lfsr_q      <= LFSR_SEED;
      presc_q     <= '0;
      busy_seen_q <= 1'b0;
      req_q       <= 1'b0;
      pix_q       <= '0;
      nib_q       <= '0;
      for (int k = 0; k < 16; k++)          v_q[k]     <= '0;
      for (int k = 0; k < STACK_DEPTH; k++) stack_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      i_q         <= i_d;
      sp_q        <= sp_d;
      hi_q        <= hi_d;
      lfsr_q      <= lfsr_next(lfsr_q);
      presc_q     <= tick ? PW'(PRESCALE - 1) : presc_q - PW'(1);
      busy_seen_q <= busy_seen_d;
      req_q       <= req_d;
      pix_q       <= pix_d;
      nib_q       <= nib_d;
      if (v_wr)  v_q[v_wa]  <= v_wd;
      if (vf_wr) v_q[4'hF]  <= {7'd0, vf_wd};
      if (push)  stack_q[push_idx] <= pc_q + TWO;
    end
  end

  chip8_timer u_dt (.clk(clk), .rst_n(rst_n), .tick_i(tick), .load_i(dt_ld),
                    .load_val_i(vx), .cnt_o(dt_cnt));
  chip8_timer u_st (.clk(clk), .rst_n(rst_n), .tick_i(tick), .load_i(st_ld),
                    .load_val_i(vx), .cnt_o(st_cnt));

  assign bus.mem_re         = mem_re;
  assign bus.mem_raddr      = raddr;
  assign bus.draw_req       = req_q;
  assign bus.draw_start_pix = pix_q;
  assign bus.draw_nibbles   = nib_q;
  assign bus.draw_I         = i_q;
  assign sound              = (st_cnt != 8'h00);
  assign halted             = (state_q == S_HALT);
endmodule

// File: tb/tb_chip8_core.sv
// Directed and randomized bench for chip8_core with an instruction-level
// reference model, a 1-cycle-latency program memory and a draw-unit stub.
module tb_chip8_core;
  localparam int AW = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = 16'h0000;
  logic        sound, halted;
  logic [7:0]  mem [4096];
  int          busy_cnt = 0;
  int          req_count = 0;
  logic        col_val = 1'b0;
  int          n_err = 0;
  int          n_checks = 0;
  int          mv [16];
  int          mi, mpc;

  chip8_if #(.ADDR_WIDTH(AW)) bus ();

  chip8_core #(
    .ADDR_WIDTH(AW), .PC_RESET(512), .STACK_DEPTH(2),
    .CLK_HZ(600), .TIMER_HZ(60), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .keys(keys), .sound(sound), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_re) bus.mem_q <= mem[bus.mem_raddr];

  always @(posedge clk) begin
    if (bus.draw_req) begin
      busy_cnt  <= 20;
      req_count <= req_count + 1;
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.draw_busy = (busy_cnt > 0);
  assign bus.draw_col  = col_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic begin_prog();
    rst_n = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
  endtask

  task automatic put(input int addr, input logic [15:0] op);
    mem[addr]     = op[15:8];
    mem[addr + 1] = op[7:0];
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] gen_op();
    logic [3:0] x, y, an;
    logic [7:0] nn, sn;
    logic [3:0] alu [9];
    alu = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
    x  = 4'($urandom_range(0, 15));
    y  = 4'($urandom_range(0, 15));
    nn = 8'($urandom_range(0, 255));
    sn = 8'($urandom_range(0, 7));
    an = alu[$urandom_range(0, 8)];
    case ($urandom_range(0, 13))
      0:       return {4'h6, x, sn};
      1:       return {4'h6, x, nn};
      2:       return {4'h7, x, nn};
      3:       return {4'h3, x, sn};
      4:       return {4'h4, x, sn};
      5:       return {4'h5, x, y, 4'h0};
      6:       return {4'h9, x, y, 4'h0};
      7:       return {4'hA, x, nn};
      8:       return {4'hF, x, 8'h1E};
      9:       return {4'hF, x, 8'h29};
      10:      return {4'hE, x, 8'h9E};
      11:      return {4'hE, x, 8'hA1};
      default: return {4'h8, x, y, an};
    endcase
  endfunction

  task automatic model_exec(output int xo);
    logic [15:0] op;
    int x, y, nn, nnn, vx, vy, r, f, npc;
    bit wf, pressed;
    op  = {mem[mpc], mem[(mpc + 1) % 4096]};
    x   = int'(op[11:8]);
    y   = int'(op[7:4]);
    nn  = int'(op[7:0]);
    nnn = int'(op[11:0]);
    vx  = mv[x];
    vy  = mv[y];
    npc = mpc + 2;
    wf  = 1'b0;
    r   = vx;
    f   = 0;
    pressed = keys[vx % 16];
    case (op[15:12])
      4'h3: if (vx == nn) npc = mpc + 4;
      4'h4: if (vx != nn) npc = mpc + 4;
      4'h5: if (vx == vy) npc = mpc + 4;
      4'h9: if (vx != vy) npc = mpc + 4;
      4'h6: mv[x] = nn;
      4'h7: mv[x] = (vx + nn) % 256;
      4'h8: begin
        case (op[3:0])
          4'h0: r = vy;
          4'h1: r = vx | vy;
          4'h2: r = vx & vy;
          4'h3: r = vx ^ vy;
          4'h4: begin r = (vx + vy) % 256;       f = (vx + vy > 255) ? 1 : 0; wf = 1'b1; end
          4'h5: begin r = (vx - vy + 256) % 256; f = (vx >= vy) ? 1 : 0;      wf = 1'b1; end
          4'h6: begin r = vx / 2;                f = vx % 2;                  wf = 1'b1; end
          4'h7: begin r = (vy - vx + 256) % 256; f = (vy >= vx) ? 1 : 0;      wf = 1'b1; end
          default: begin r = (vx * 2) % 256;     f = vx / 128;                wf = 1'b1; end
        endcase
        mv[x] = r;
        if (wf) mv[15] = f;
      end
      4'hA: mi = nnn;
      4'hE: begin
        if (nn == 'h9E && pressed)  npc = mpc + 4;
        if (nn == 'hA1 && !pressed) npc = mpc + 4;
      end
      4'hF: begin
        if (nn == 'h1E) mi = (mi + vx) % 4096;
        else            mi = 5 * (vx % 16);
      end
      default: ;
    endcase
    mpc = npc % 4096;
    xo  = x;
  endtask

  initial begin
    int t, xr;

    // 00EE straight out of reset: underflow halts with PC held
    begin_prog();
    put(12'h200, 16'h00EE);
    #1;
    check("rst_halted", halted, 1'b0);
    check("rst_sound", sound, 1'b0);
    check("rst_draw_req", bus.draw_req, 1'b0);
    check("rst_pc", dut.pc_q, 12'h200);
    check("rst_sp", dut.sp_q, 0);
    check("rst_i", dut.i_q, 0);
    release_reset();
    cycles(3);
    check("ret_uflow_halted", halted, 1'b1);
    check("ret_uflow_pc", dut.pc_q, 12'h200);
    cycles(10);
    check("halt_no_fetch", bus.mem_re, 1'b0);
    check("halt_sticky", halted, 1'b1);

    // CALL then RET
    begin_prog();
    put(12'h200, 16'h2208);
    put(12'h202, 16'h1202);
    put(12'h208, 16'h00EE);
    release_reset();
    cycles(3);
    check("call_pc", dut.pc_q, 12'h208);
    check("call_sp", dut.sp_q, 1);
    cycles(3);
    check("ret_pc", dut.pc_q, 12'h202);
    check("ret_sp", dut.sp_q, 0);
    check("ret_halted", halted, 1'b0);

    // third nested CALL overflows a 2-deep stack
    begin_prog();
    put(12'h200, 16'h2202);
    put(12'h202, 16'h2204);
    put(12'h204, 16'h2206);
    release_reset();
    cycles(9);
    check("ovf_halted", halted, 1'b1);
    check("ovf_sp", dut.sp_q, 2);
    check("ovf_pc", dut.pc_q, 12'h204);

    // ALU sequence, 3 cycles per instruction
    begin_prog();
    put(12'h200, 16'h61FE);
    put(12'h202, 16'h6005);
    put(12'h204, 16'h7003);
    put(12'h206, 16'h8014);
    put(12'h208, 16'h1208);
    release_reset();
    cycles(12);
    check("alu_pc", dut.pc_q, 12'h208);
    check("alu_v0", dut.v_q[0], 8'h06);
    check("alu_vf", dut.v_q[15], 8'h01);
    check("alu_v1", dut.v_q[1], 8'hFE);

    // keypad skips with key 7 held
    begin_prog();
    keys = 16'h0080;
    put(12'h200, 16'h6107);
    put(12'h202, 16'hE19E);
    put(12'h206, 16'hE1A1);
    put(12'h208, 16'h1208);
    release_reset();
    cycles(6);
    check("skp_pc", dut.pc_q, 12'h206);
    cycles(3);
    check("sknp_pc", dut.pc_q, 12'h208);
    check("keys_halted", halted, 1'b0);
    keys = 16'h0000;

    // timers: ticks land on edges 1,11,21,...; FA15 executes on edge 21
    begin_prog();
    put(12'h200, 16'h6A05);
    for (int k = 1; k < 6; k++) put(12'h200 + 2 * k, 16'h6B00);
    put(12'h20C, 16'hFA15);
    put(12'h20E, 16'hFA18);
    for (int k = 8; k < 16; k++) put(12'h200 + 2 * k, 16'h6B00);
    put(12'h220, 16'hF107);
    put(12'h222, 16'h1222);
    release_reset();
    cycles(21);
    check("dt_load_on_tick", dut.dt_cnt, 5);
    cycles(3);
    check("st_sound_on", sound, 1'b1);
    cycles(7);
    check("dt_dec1", dut.dt_cnt, 4);
    cycles(20);
    check("fx07_pretick", dut.v_q[1], 3);
    check("dt_edge51", dut.dt_cnt, 2);
    cycles(10);
    check("st_sound_still", sound, 1'b1);
    check("dt_edge61", dut.dt_cnt, 1);
    cycles(10);
    check("dt_zero", dut.dt_cnt, 0);
    check("st_sound_off", sound, 1'b0);
    cycles(30);
    check("dt_saturate", dut.dt_cnt, 0);

    // DXYN handoff
    begin_prog();
    col_val = 1'b1;
    put(12'h200, 16'h610A);
    put(12'h202, 16'h6203);
    put(12'h204, 16'hA300);
    put(12'h206, 16'hD125);
    put(12'h208, 16'h1208);
    req_count = 0;
    release_reset();
    cycles(12);
    check("draw_req_pulse", bus.draw_req, 1'b1);
    check("draw_pix", bus.draw_start_pix, {5'd3, 6'd10});
    check("draw_nib", bus.draw_nibbles, 4'd5);
    check("draw_I", bus.draw_I, 12'h300);
    check("draw_mem_re", bus.mem_re, 1'b0);
    cycles(1);
    check("draw_req_drop", bus.draw_req, 1'b0);
    t = 0;
    while (dut.pc_q !== 12'h208 && t < 100) begin
      cycles(1);
      t++;
    end
    check("draw_done_cycles", t, 21);
    check("draw_vf", dut.v_q[15], 8'h01);
    check("draw_req_count", req_count, 1);

    // reset asserted while the draw request is out
    begin_prog();
    put(12'h200, 16'h610A);
    put(12'h202, 16'h6203);
    put(12'h204, 16'hA300);
    put(12'h206, 16'hD125);
    release_reset();
    cycles(12);
    check("mid_draw_req", bus.draw_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", bus.draw_req, 1'b0);
    check("mid_rst_pc", dut.pc_q, 12'h200);
    check("mid_rst_v1", dut.v_q[1], 0);
    check("mid_rst_i", dut.i_q, 0);

    // randomized straight-line programs against the reference model
    begin_prog();
    keys = 16'($urandom);
    for (int a = 12'h200; a < 12'h600; a += 2) put(a, gen_op());
    for (int k = 0; k < 16; k++) mv[k] = 0;
    mi  = 0;
    mpc = 12'h200;
    release_reset();
    for (int k = 0; k < 150; k++) begin
      cycles(3);
      model_exec(xr);
      check("rnd_pc", dut.pc_q, mpc);
      check("rnd_vx", dut.v_q[xr], mv[xr]);
      check("rnd_vf", dut.v_q[15], mv[15]);
      check("rnd_i", dut.i_q, mi);
    end
    for (int k = 0; k < 16; k++) check("rnd_final_v", dut.v_q[k], mv[k]);
    check("rnd_halted", halted, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
